// File: rtl/shared_event_fifo.sv
// -----------------------------------------------------------------------------
// shared_event_fifo
//   Single-clock event FIFO between the event router and the downstream
//   serializer. Each routed event (WIDTH-1 bits) is stored with an odd-parity
//   bit in the MSB. Pops produce a registered packet plus a one-cycle valid
//   pulse. Events arriving while the FIFO is full are dropped and recorded in
//   a sticky overflow flag.
//
// Ports
//   clk            in   master clock, all state changes on the rising edge
//   reset          in   synchronous active-high reset
//   event_in       in   [WIDTH-2:0] routed channel event
//   load_event     in   one-cycle write strobe
//   read_fifo      in   pop request from the serializer
//   clear_overflow in   clears the sticky overflow flag
//   packet_out     out  [WIDTH-1:0] registered popped packet {parity, event}
//   packet_valid   out  one-cycle pulse when packet_out was updated
//   fifo_full      out  occupancy == FIFO_DEPTH
//   fifo_half      out  occupancy >= FIFO_DEPTH/2
//   fifo_empty     out  occupancy == 0
//   fifo_counter   out  [FIFO_BITS:0] occupancy, 0..FIFO_DEPTH
//   fifo_overflow  out  sticky: at least one event was dropped
// -----------------------------------------------------------------------------
module shared_event_fifo #(
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 2048,
  parameter int FIFO_BITS  = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-2:0]     event_in,
  input  logic                 load_event,
  input  logic                 read_fifo,
  input  logic                 clear_overflow,
  output logic [WIDTH-1:0]     packet_out,
  output logic                 packet_valid,
  output logic                 fifo_full,
  output logic                 fifo_half,
  output logic                 fifo_empty,
  output logic [FIFO_BITS:0]   fifo_counter,
  output logic                 fifo_overflow
);

  localparam logic [FIFO_BITS:0]   DEPTH_C = (FIFO_BITS+1)'(FIFO_DEPTH);
  localparam logic [FIFO_BITS:0]   HALF_C  = (FIFO_BITS+1)'(FIFO_DEPTH / 2);
  localparam logic [FIFO_BITS:0]   CNT_ONE = (FIFO_BITS+1)'(1);
  localparam logic [FIFO_BITS-1:0] PTR_ONE = FIFO_BITS'(1);

  // Parity bit that makes {parity, ev} carry an odd number of ones.
  function automatic logic odd_parity(input logic [WIDTH-2:0] ev);
    return ~(^ev);
  endfunction

  logic [WIDTH-1:0]     mem_q [FIFO_DEPTH];

  logic [FIFO_BITS-1:0] wptr_q, wptr_d;
  logic [FIFO_BITS-1:0] rptr_q, rptr_d;
  logic [FIFO_BITS:0]   count_q, count_d;
  logic [WIDTH-1:0]     pkt_q, pkt_d;
  logic                 pvalid_q, pvalid_d;
  logic                 full_q, full_d;
  logic                 half_q, half_d;
  logic                 empty_q, empty_d;
  logic                 ovf_q, ovf_d;

  logic                 rd_acc_s;
  logic                 wr_acc_s;
  logic                 drop_s;

  // Accept/drop decisions; a read frees a slot for a same-cycle write at full,
  // but a write never satisfies a same-cycle read at empty.
  always_comb begin
    rd_acc_s = 1'b0;
    wr_acc_s = 1'b0;
    drop_s   = 1'b0;
    if (reset) begin
      rd_acc_s = 1'b0;
      wr_acc_s = 1'b0;
      drop_s   = 1'b0;
    end else begin
      rd_acc_s = read_fifo && (count_q != {(FIFO_BITS+1){1'b0}});
      wr_acc_s = load_event && ((count_q < DEPTH_C) || rd_acc_s);
      drop_s   = load_event && !wr_acc_s;
    end
  end

  // Next-state for pointers, occupancy, output packet and flags.
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    pkt_d    = pkt_q;
    pvalid_d = 1'b0;
    ovf_d    = ovf_q;

    if (wr_acc_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end

    if (rd_acc_s) begin
      rptr_d   = rptr_q + PTR_ONE;
      pkt_d    = mem_q[rptr_q];
      pvalid_d = 1'b1;
    end else begin
      rptr_d   = rptr_q;
      pkt_d    = pkt_q;
      pvalid_d = 1'b0;
    end

    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear wins, so no dropped event goes unseen.
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clear_overflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    // Flags are registered copies decoded from the next counter value, so
    // they always equal a decode of the registered counter.
    empty_d = (count_d == {(FIFO_BITS+1){1'b0}});
    full_d  = (count_d == DEPTH_C);
    half_d  = (count_d >= HALF_C);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q   <= {FIFO_BITS{1'b0}};
      rptr_q   <= {FIFO_BITS{1'b0}};
      count_q  <= {(FIFO_BITS+1){1'b0}};
      pkt_q    <= {WIDTH{1'b0}};
      pvalid_q <= 1'b0;
      full_q   <= 1'b0;
      half_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      pkt_q    <= pkt_d;
      pvalid_q <= pvalid_d;
      full_q   <= full_d;
      half_q   <= half_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array: not reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wptr_q] <= {odd_parity(event_in), event_in};
    end
  end

  assign packet_out    = pkt_q;
  assign packet_valid  = pvalid_q;
  assign fifo_full     = full_q;
  assign fifo_half     = half_q;
  assign fifo_empty    = empty_q;
  assign fifo_counter  = count_q;
  assign fifo_overflow = ovf_q;

endmodule

// File: tb/tb_shared_event_fifo.sv
module tb_shared_event_fifo;

  localparam int WIDTH = 64;
  localparam int DEPTH = 8;
  localparam int BITS  = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-2:0] event_in = '0;
  logic             load_event = 1'b0;
  logic             read_fifo = 1'b0;
  logic             clear_overflow = 1'b0;
  logic [WIDTH-1:0] packet_out;
  logic             packet_valid;
  logic             fifo_full, fifo_half, fifo_empty, fifo_overflow;
  logic [BITS:0]    fifo_counter;

  shared_event_fifo #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .FIFO_BITS(BITS)) dut (
    .clk(clk), .reset(reset), .event_in(event_in), .load_event(load_event),
    .read_fifo(read_fifo), .clear_overflow(clear_overflow),
    .packet_out(packet_out), .packet_valid(packet_valid),
    .fifo_full(fifo_full), .fifo_half(fifo_half), .fifo_empty(fifo_empty),
    .fifo_counter(fifo_counter), .fifo_overflow(fifo_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: a queue of events plus the visible output state.
  logic [WIDTH-2:0] mq[$];
  logic [WIDTH-1:0] m_pkt = '0;
  logic             m_pv  = 1'b0;
  logic             m_ovf = 1'b0;

  function automatic logic [WIDTH-1:0] make_pkt(input logic [WIDTH-2:0] ev);
    logic p;
    p = (($countones(ev) % 2) == 0);
    return {p, ev};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".packet_out"}, packet_out, m_pkt);
    chk({tag, ".packet_valid"}, 64'(packet_valid), 64'(m_pv));
    chk({tag, ".counter"}, 64'(fifo_counter), 64'(mq.size()));
    chk({tag, ".empty"}, 64'(fifo_empty), 64'(mq.size() == 0));
    chk({tag, ".full"}, 64'(fifo_full), 64'(mq.size() == DEPTH));
    chk({tag, ".half"}, 64'(fifo_half), 64'(mq.size() >= DEPTH / 2));
    chk({tag, ".overflow"}, 64'(fifo_overflow), 64'(m_ovf));
  endtask

  // One clock: drive inputs, advance the model, check all outputs.
  task automatic step(input string tag, input logic rst, input logic le,
                      input logic [WIDTH-2:0] ev, input logic rd, input logic clr);
    logic rd_ok, wr_ok, drop;
    reset = rst; load_event = le; event_in = ev; read_fifo = rd; clear_overflow = clr;
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_pkt = '0; m_pv = 1'b0; m_ovf = 1'b0;
    end else begin
      rd_ok = rd && (mq.size() > 0);
      wr_ok = le && ((mq.size() < DEPTH) || rd_ok);
      drop  = le && !wr_ok;
      m_pv  = rd_ok;
      if (rd_ok) m_pkt = make_pkt(mq.pop_front());
      if (wr_ok) mq.push_back(ev);
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    #1;
    check_all(tag);
  endtask

  task automatic wr(input string tag, input logic [WIDTH-2:0] ev);
    step(tag, 1'b0, 1'b1, ev, 1'b0, 1'b0);
  endtask

  task automatic rd(input string tag);
    step(tag, 1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [WIDTH-2:0] rev;
    // Reset state
    step("reset0", 1'b1, 1'b0, '0, 1'b0, 1'b0);
    step("reset1", 1'b1, 1'b1, 63'h5, 1'b1, 1'b0);

    // Single write/read, parity 0 for event 1
    wr("w1", 63'h1);
    rd("r1");
    chk("r1.const_pkt", packet_out, 64'h0000_0000_0000_0001);
    idle("idle1");
    chk("idle1.single_pulse", 64'(packet_valid), 64'h0);

    // Fill, overflow, drain in order
    for (int i = 0; i < 8; i++) wr("fill", 63'(i));
    wr("drop9", 63'h9);
    chk("drop9.const_ovf", 64'(fifo_overflow), 64'h1);
    for (int i = 0; i < 8; i++) rd("drain");
    chk("drain.const_last", packet_out, 64'h0000_0000_0000_0007);
    rd("rd_empty");
    step("clr0", 1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Simultaneous read+write at full
    for (int i = 0; i < 8; i++) wr("fill2", 63'(16 + i));
    step("rw_full", 1'b0, 1'b1, 63'h77, 1'b1, 1'b0);
    chk("rw_full.const_pkt", packet_out, {1'b0, 63'h10});
    for (int i = 0; i < 8; i++) rd("drain2");

    // Simultaneous read+write at empty
    step("rw_empty", 1'b0, 1'b1, 63'h3, 1'b1, 1'b0);
    rd("rw_empty_rd");

    // Pointer wrap
    for (int i = 0; i < 20; i++) begin
      wr("wrap_w", 63'(100 + i));
      rd("wrap_r");
    end

    // Overflow then clear; clear coincident with a drop keeps the flag
    for (int i = 0; i < 8; i++) wr("fill3", 63'(200 + i));
    wr("drop_a", 63'h1FF);
    step("clr_a", 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("clr_a.const_ovf", 64'(fifo_overflow), 64'h0);
    step("clr_drop", 1'b0, 1'b1, 63'h2FF, 1'b0, 1'b1);
    chk("clr_drop.const_ovf", 64'(fifo_overflow), 64'h1);

    // Reset mid-operation
    step("rst_mid", 1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) wr("pre_rst", 63'(300 + i));
    step("rst_5", 1'b1, 1'b1, 63'h44, 1'b1, 1'b0);
    rd("post_rst_rd");
    chk("post_rst_rd.const_pv", 64'(packet_valid), 64'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rev = {$urandom(), $urandom()};
      step("rand", ($urandom_range(0, 60) == 0), ($urandom_range(0, 99) < 60), rev,
           ($urandom_range(0, 99) < 45), ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/shared_event_fifo.md
SHARED_EVENT_FIFO -- requirements
Module: shared_event_fifo

Interface
REQ-001 Parameter WIDTH, default 64: packet width; stored event is WIDTH-1 bits plus 1 parity bit.
REQ-002 Parameter FIFO_DEPTH, default 2048: number of entries; SHALL be a power of 2 and at least 4.
REQ-003 Parameter FIFO_BITS, default 11: log2(FIFO_DEPTH).
REQ-004 clk  input  1  master clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 event_in  input  WIDTH-1  routed channel event from the event router.
REQ-007 load_event  input  1  high for one cycle per event to write.
REQ-008 read_fifo  input  1  high to pop one packet (downstream serializer).
REQ-009 clear_overflow  input  1  high to clear the sticky overflow flag.
REQ-010 packet_out  output  WIDTH  registered popped packet {parity, event}.
REQ-011 packet_valid  output  1  one-cycle pulse: packet_out updated this cycle.
REQ-012 fifo_full / fifo_half / fifo_empty  output  1 each  occupancy flags.
REQ-013 fifo_counter  output  FIFO_BITS+1  current occupancy, 0..FIFO_DEPTH.
REQ-014 fifo_overflow  output  1  sticky: at least one event dropped.

Function
REQ-015 Storage SHALL be a FIFO_DEPTH x WIDTH array with FIFO_BITS-bit write and read pointers; each pointer wraps from FIFO_DEPTH-1 to 0.
REQ-016 On accepted write, the entry SHALL store {odd parity over event_in, event_in}: MSB is set so the WIDTH-bit packet has odd weight.
REQ-017 Write accepted when load_event=1 and (fifo_counter<FIFO_DEPTH or read accepted same cycle); wptr increments.
REQ-018 load_event=1 while full and no accepted read: event dropped; no state change except fifo_overflow<=1 next cycle.
REQ-019 Read accepted when read_fifo=1 and fifo_counter>0; next cycle packet_out = entry at rptr, packet_valid=1; rptr increments.
REQ-020 read_fifo=1 while empty: ignored; packet_out holds; packet_valid=0; no fall-through of a same-cycle write.
REQ-021 Latency: a packet written at edge N is readable at N+1 and appears on packet_out one edge after the accepted read.
REQ-022 fifo_counter: +1 on write only, -1 on read only, unchanged on both or neither; registered.
REQ-023 Flags SHALL be decoded from the registered counter: empty = counter==0, full = counter==FIFO_DEPTH, half = counter>=FIFO_DEPTH/2.
REQ-024 Simultaneous read and write at full: both accepted, counter stays FIFO_DEPTH, no overflow.
REQ-025 Simultaneous read and write at empty: write accepted, read ignored, counter becomes 1.
REQ-026 clear_overflow=1 clears fifo_overflow next cycle, unless a drop occurs the same cycle; then the flag stays 1.
REQ-027 packet_valid SHALL never be high for two cycles from a single read_fifo pulse; back-to-back reads give one pulse per accepted read.

Reset
REQ-028 reset=1 at a clock edge: pointers=0, fifo_counter=0, fifo_empty=1, fifo_full=0, fifo_half=0, fifo_overflow=0, packet_valid=0, packet_out=0.
REQ-029 Reset mid-operation discards all stored entries; load_event and read_fifo are ignored during any cycle with reset=1.
REQ-030 Memory contents need not be cleared; no output may expose unwritten entries.

Verification (FIFO_DEPTH=8, FIFO_BITS=3, WIDTH=64)
REQ-031 Reset, then write event 63'h1 -> next cycle counter=1, empty=0; read -> packet_out=64'h0000_0000_0000_0001 (parity 0), packet_valid pulse; then empty=1.
REQ-032 Write 8 events 63'h0..63'h7 -> half=1 at counter=4, full=1 at 8; write a 9th -> dropped, overflow=1, counter=8; 8 reads return 0..7 in order with parity bits 1,0,0,1,0,1,1,0.
REQ-033 At full, assert load_event and read_fifo together -> counter stays 8, overflow stays 0, popped packet = oldest entry.
REQ-034 At empty, assert load_event and read_fifo together -> no packet_valid, counter=1; next read returns the written event.
REQ-035 Run 20 write/read pairs to force pointer wrap -> data order preserved; then overflow then clear_overflow -> flag returns to 0; clear coincident with a drop -> flag stays 1.
REQ-036 Write 5 events, assert reset for one cycle -> all flags and counter at reset values; a following read yields no packet_valid.
